add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 22 ++
 rtl/add_arbiter_add.sv | 25 ++
 rtl/add_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_add_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// add_arbiter_pkg
//
// Shared definitions for the add_arbiter block:
//   - state_t      : FSM state encoding (IDLE, CALC, DONE)
//   - DEF_NUM_REQ  : default number of requesters sharing the adder
//   - DEF_WIDTH    : default operand / result width in bits
//
// No ports (package).
// ----------------------------------------------------------------------------
package add_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : add_arbiter_pkg

// File: rtl/add_arbiter_add.sv
// ----------------------------------------------------------------------------
// add_arbiter_add
//
// Combinational adder shared by all requesters of add_arbiter. The sum is
// modulo 2^WIDTH; callers that need the carry instantiate it one bit wider
// and zero-extend the operands.
//
// Ports:
//   DataIn0  in  [WIDTH-1:0]  operand A
//   DataIn1  in  [WIDTH-1:0]  operand B
//   DataOut  out [WIDTH-1:0]  A + B (wraps)
// ----------------------------------------------------------------------------
module add_arbiter_add
    import add_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] DataIn0,
    input  logic [WIDTH-1:0] DataIn1,
    output logic [WIDTH-1:0] DataOut
);

    assign DataOut = DataIn0 + DataIn1;

endmodule : add_arbiter_add

// File: rtl/add_arbiter.sv
// ----------------------------------------------------------------------------
// add_arbiter
//
// NUM_REQ requesters share a single adder. A round-robin arbiter picks one
// requester while idle, latches its two operands, computes the sum in the
// following cycle and holds the result until the consumer acknowledges it.
//
// FSM: IDLE -> (any Req) -> CALC -> DONE -> (Ack) -> IDLE
//
// Optional feature (compile-time macro ADD_ARB_CARRY_EN):
//   defined   : CarryOut port present, carries bit WIDTH of the WIDTH+1-bit sum
//   undefined : no CarryOut port, adder is exactly WIDTH bits
//
// Ports:
//   Clk       in   1                  clock, rising edge
//   Rst_n     in   1                  synchronous active-low reset
//   Req       in   [NUM_REQ-1:0]      per-requester request
//   DataIn0   in   [NUM_REQ*WIDTH-1:0] operand A, WIDTH-bit slice per requester
//   DataIn1   in   [NUM_REQ*WIDTH-1:0] operand B, same slicing
//   Ack       in   1                  consumer takes the result (DONE only)
//   Gnt       out  [NUM_REQ-1:0]      registered one-hot grant, one cycle
//   DataOut   out  [WIDTH-1:0]        registered sum
//   Valid     out  1                  result valid, held until Ack
//   ReqId     out  [clog2(NUM_REQ)-1:0] owner of DataOut
//   CarryOut  out  1                  (ADD_ARB_CARRY_EN only) sum carry
//   Busy      out  1                  FSM not in IDLE
// ----------------------------------------------------------------------------
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] DataIn0,
    input  logic [NUM_REQ*WIDTH-1:0] DataIn1,
    input  logic                     Ack,
    output logic [NUM_REQ-1:0]       Gnt,
    output logic [WIDTH-1:0]         DataOut,
    output logic                     Valid,
    output logic [ID_W-1:0]          ReqId,
`ifdef ADD_ARB_CARRY_EN
    output logic                     CarryOut,
`endif
    output logic                     Busy
);

`ifdef ADD_ARB_CARRY_EN
    localparam int SUM_W = WIDTH + 1;
`else
    localparam int SUM_W = WIDTH;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    data_out_q, data_out_d;
    logic [ID_W-1:0]     req_id_q, req_id_d;
    logic [WIDTH-1:0]    op_a_q, op_a_d;
    logic [WIDTH-1:0]    op_b_q, op_b_d;
`ifdef ADD_ARB_CARRY_EN
    logic                carry_q, carry_d;
`endif

    // Arbitration results
    logic                found;
    logic [ID_W-1:0]     win;
    logic [ID_W-1:0]     idx;
    logic [WIDTH-1:0]    win_a;
    logic [WIDTH-1:0]    win_b;

    // Adder result
    logic [SUM_W-1:0]    sum;

    // ------------------------------------------------------------------
    // Round-robin search starting at ptr_q. NUM_REQ is a power of two, so
    // the ID_W-bit addition wraps modulo NUM_REQ for free.
    // ------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + ID_W'(k);
            if (!found && Req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Operand slice of the winning requester
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_a = DataIn0[i*WIDTH +: WIDTH];
                win_b = DataIn1[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared adder; operates on the operands latched at grant time so
    // DataIn may change freely while the operation is in flight.
    // ------------------------------------------------------------------
    add_arbiter_add #(
        .WIDTH (SUM_W)
    ) u_add (
        .DataIn0 (SUM_W'(op_a_q)),
        .DataIn1 (SUM_W'(op_b_q)),
        .DataOut (sum)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;
        data_out_d = data_out_q;
        req_id_d   = req_id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
`ifdef ADD_ARB_CARRY_EN
        carry_d    = carry_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    op_a_d   = win_a;
                    op_b_d   = win_b;
                    gnt_d    = NUM_REQ'(1) << win;
                    req_id_d = win;
                    ptr_d    = win + ID_W'(1);
                    state_d  = CALC;
                end
            end

            CALC: begin
                data_out_d = sum[WIDTH-1:0];
`ifdef ADD_ARB_CARRY_EN
                carry_d    = sum[WIDTH];
`endif
                valid_d    = 1'b1;
                gnt_d      = '0;
                state_d    = DONE;
            end

            DONE: begin
                // Valid is always high here, so Ack is only ever honoured
                // while a result is being presented.
                if (Ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and result registers (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            req_id_q   <= '0;
`ifdef ADD_ARB_CARRY_EN
            carry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            req_id_q   <= req_id_d;
`ifdef ADD_ARB_CARRY_EN
            carry_q    <= carry_d;
`endif
        end
    end

    // Operand latches carry no reset: they are only consumed in CALC,
    // which is always preceded by a grant that loads them.
    always_ff @(posedge Clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Gnt      = gnt_q;
    assign DataOut  = data_out_q;
    assign Valid    = valid_q;
    assign ReqId    = req_id_q;
`ifdef ADD_ARB_CARRY_EN
    assign CarryOut = carry_q;
`endif
    assign Busy     = (state_q != IDLE);

endmodule : add_arbiter

// File: tb/tb_add_arbiter.sv
// ----------------------------------------------------------------------------
// tb_add_arbiter
//
// Directed + randomized bench for add_arbiter (NUM_REQ=4, WIDTH=32). A
// transaction-level model tracks the round-robin pointer and the expected
// sum/carry with plain 64-bit arithmetic.
// ----------------------------------------------------------------------------
module tb_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int ID_W    = 2;

    logic                     Clk = 1'b0;
    logic                     Rst_n;
    logic [NUM_REQ-1:0]       Req;
    logic [NUM_REQ*WIDTH-1:0] DataIn0;
    logic [NUM_REQ*WIDTH-1:0] DataIn1;
    logic                     Ack;
    logic [NUM_REQ-1:0]       Gnt;
    logic [WIDTH-1:0]         DataOut;
    logic                     Valid;
    logic [ID_W-1:0]          ReqId;
`ifdef ADD_ARB_CARRY_EN
    logic                     CarryOut;
`endif
    logic                     Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int               m_ptr;
    logic [WIDTH-1:0] m_last_sum;

    always #5 Clk = ~Clk;

    add_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Req      (Req),
        .DataIn0  (DataIn0),
        .DataIn1  (DataIn1),
        .Ack      (Ack),
        .Gnt      (Gnt),
        .DataOut  (DataOut),
        .Valid    (Valid),
        .ReqId    (ReqId),
`ifdef ADD_ARB_CARRY_EN
        .CarryOut (CarryOut),
`endif
        .Busy     (Busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < NUM_REQ; i++) begin
            DataIn0[i*WIDTH +: WIDTH] = $urandom;
            DataIn1[i*WIDTH +: WIDTH] = $urandom;
        end
    endtask

    // First requester at or after the pointer, wrapping around.
    function automatic int pick(input logic [NUM_REQ-1:0] r);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Full transaction from IDLE: grant, compute, hold ack_delay cycles, ack.
    task automatic txn(input logic [NUM_REQ-1:0] r, input int ack_delay);
        int               w;
        logic [63:0]      s;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_c;
        w       = pick(r);
        s       = {32'd0, DataIn0[w*WIDTH +: WIDTH]} + {32'd0, DataIn1[w*WIDTH +: WIDTH]};
        exp_sum = s[WIDTH-1:0];
        exp_c   = s[WIDTH];

        Req = r;
        Ack = 1'b0;
        step();
        chk("gnt_onehot", 64'(Gnt), 64'd1 << w);
        chk("busy_calc", 64'(Busy), 64'd1);
        chk("valid_calc", 64'(Valid), 64'd0);
        m_ptr = (w + 1) % NUM_REQ;

        // Requester drops Req after its grant; operands change under it.
        Req = '0;
        scramble();
        step();
        chk("valid_done", 64'(Valid), 64'd1);
        chk("sum", 64'(DataOut), 64'(exp_sum));
        chk("reqid", 64'(ReqId), 64'(w));
        chk("gnt_clear", 64'(Gnt), 64'd0);
`ifdef ADD_ARB_CARRY_EN
        chk("carry", 64'(CarryOut), 64'(exp_c));
`else
        if (exp_c) $display("note: carry dropped (carry port disabled)");
`endif

        for (int i = 0; i < ack_delay; i++) begin
            Req = 4'($urandom);
            scramble();
            step();
            chk("hold_valid", 64'(Valid), 64'd1);
            chk("hold_sum", 64'(DataOut), 64'(exp_sum));
            chk("hold_reqid", 64'(ReqId), 64'(w));
            chk("hold_nognt", 64'(Gnt), 64'd0);
        end

        Req = '0;
        Ack = 1'b1;
        step();
        chk("valid_acked", 64'(Valid), 64'd0);
        chk("busy_idle", 64'(Busy), 64'd0);
        chk("sum_kept", 64'(DataOut), 64'(exp_sum));
        Ack = 1'b0;
        m_last_sum = exp_sum;
    endtask

    initial begin
        logic [ID_W-1:0] order [5];
        int w;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

        // Reset
        Rst_n = 1'b0;
        Req   = '0;
        Ack   = 1'b0;
        scramble();
        step();
        step();
        chk("rst_gnt", 64'(Gnt), 64'd0);
        chk("rst_valid", 64'(Valid), 64'd0);
        chk("rst_dataout", 64'(DataOut), 64'd0);
        chk("rst_reqid", 64'(ReqId), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
`ifdef ADD_ARB_CARRY_EN
        chk("rst_carry", 64'(CarryOut), 64'd0);
`endif
        m_ptr = 0;
        Rst_n = 1'b1;
        step();

        // All four requesting repeatedly: pointer walks and wraps.
        for (int i = 0; i < 5; i++) begin
            scramble();
            txn(4'b1111, 0);
            chk("rr_order", 64'(ReqId), 64'(order[i]));
        end

        // Single request from requester 1: 5 + 7.
        scramble();
        DataIn0[1*WIDTH +: WIDTH] = 32'd5;
        DataIn1[1*WIDTH +: WIDTH] = 32'd7;
        txn(4'b0010, 0);
        chk("single_sum", 64'(DataOut), 64'd12);
        chk("single_id", 64'(ReqId), 64'd1);

        // Idle with no request: nothing moves; stray Ack ignored.
        for (int i = 0; i < 3; i++) begin
            Ack = (i == 1);
            step();
            chk("idle_busy", 64'(Busy), 64'd0);
            chk("idle_gnt", 64'(Gnt), 64'd0);
            chk("idle_valid", 64'(Valid), 64'd0);
            chk("idle_hold", 64'(DataOut), 64'(m_last_sum));
        end
        Ack = 1'b0;

        // Overflow wraps: FFFF_FFFF + 2 = 1.
        scramble();
        DataIn0[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        DataIn1[2*WIDTH +: WIDTH] = 32'd2;
        txn(4'b0100, 0);
        chk("ovf_sum", 64'(DataOut), 64'd1);

        // Long hold in DONE with new requests and changing operands.
        scramble();
        txn(4'b1001, 10);

        // Reset while in CALC discards the operation.
        scramble();
        w = pick(4'b0110);
        Req = 4'b0110;
        step();
        chk("pre_rst_gnt", 64'(Gnt), 64'd1 << w);
        Req   = '0;
        Rst_n = 1'b0;
        step();
        chk("calc_rst_valid", 64'(Valid), 64'd0);
        chk("calc_rst_busy", 64'(Busy), 64'd0);
        chk("calc_rst_gnt", 64'(Gnt), 64'd0);
        Rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("no_valid_pulse", 64'(Valid), 64'd0);
        end
        scramble();
        txn(4'b1111, 1);
        chk("post_rst_id", 64'(ReqId), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            scramble();
            txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_add_arbiter
